// File: rtl/inj_scheduler.sv
// NoC traffic-injection scheduler: sequences network-reset, send and cooldown phases
// and shares the injection slot among requesters with round-robin priority and a minimum grant gap.
module inj_scheduler #(
    parameter int NUM_NODES       = 9,
    parameter int RESET_CYCLES    = 5,
    parameter int SIM_CYCLES      = 10000,
    parameter int COOLDOWN_CYCLES = 20000,
    parameter int INJ_GAP         = 4,
    parameter int CNT_W           = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [NUM_NODES-1:0] req,
    output logic [NUM_NODES-1:0] grant,
    output logic                 net_reset,
    output logic                 send,
    output logic                 busy,
    output logic                 done,
    output logic [2:0]           phase,
    output logic [CNT_W-1:0]     grant_count
);

    // state | meaning
    // IDLE  | waiting for start, network held in reset
    // RST   | network reset for RESET_CYCLES
    // SEND  | injection enabled, arbitration active
    // COOL  | drain period, no new grants
    // DONE  | run complete, waiting for restart
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RST  = 3'd1,
        SEND = 3'd2,
        COOL = 3'd3,
        DONE = 3'd4
    } phase_t;

    localparam int PTR_W = $clog2(NUM_NODES);
    localparam int GAP_W = (INJ_GAP > 1) ? $clog2(INJ_GAP) : 1;

    phase_t           state;
    logic [CNT_W-1:0] phase_cnt;
    logic [CNT_W-1:0] phase_last;
    logic             phase_end;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_next;
    logic [GAP_W-1:0] gap_cnt;
    logic [PTR_W-1:0] sel_idx;
    logic             sel_found;
    logic [PTR_W:0]   idx;
    logic             arb_go;

    always_comb begin
        case (state)
            RST:     phase_last = CNT_W'(RESET_CYCLES - 1);
            SEND:    phase_last = CNT_W'(SIM_CYCLES - 1);
            COOL:    phase_last = CNT_W'(COOLDOWN_CYCLES - 1);
            default: phase_last = '0;
        endcase
    end

    assign phase_end = (phase_cnt == phase_last);

    // Scan downward in offset so the lowest offset from the pointer wins.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        idx       = '0;
        for (int k = NUM_NODES - 1; k >= 0; k--) begin
            idx = {1'b0, ptr} + (PTR_W + 1)'(k);
            if (idx >= (PTR_W + 1)'(NUM_NODES))
                idx = idx - (PTR_W + 1)'(NUM_NODES);
            if (req[idx[PTR_W-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = idx[PTR_W-1:0];
            end
        end
    end

    assign ptr_next = (sel_idx == PTR_W'(NUM_NODES - 1)) ? '0 : sel_idx + 1'b1;
    assign arb_go   = (state == SEND) && !phase_end && (gap_cnt == '0) && sel_found;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            phase_cnt   <= '0;
            ptr         <= '0;
            gap_cnt     <= '0;
            grant       <= '0;
            grant_count <= '0;
        end else begin
            grant <= '0;
            if (arb_go) begin
                grant   <= NUM_NODES'(1) << sel_idx;
                ptr     <= ptr_next;
                gap_cnt <= GAP_W'(INJ_GAP - 1);
                if (grant_count != '1)
                    grant_count <= grant_count + 1'b1;
            end else if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - 1'b1;
            end

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state       <= RST;
                        phase_cnt   <= '0;
                        grant_count <= '0;
                        ptr         <= '0;
                        gap_cnt     <= '0;
                    end
                end
                RST: begin
                    if (phase_end) begin
                        state     <= SEND;
                        phase_cnt <= '0;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                SEND: begin
                    if (phase_end) begin
                        state     <= COOL;
                        phase_cnt <= '0;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                COOL: begin
                    if (phase_end) begin
                        state     <= DONE;
                        phase_cnt <= '0;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign phase     = state;
    assign net_reset = (state == IDLE) || (state == RST);
    assign send      = (state == SEND);
    assign busy      = (state == RST) || (state == SEND) || (state == COOL);
    assign done      = (state == DONE);

endmodule
